// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-parser state encoding, frame constants and
// the receiver's baud-rate constants.
package uart_pkg;

  // Frame-parser state encoding (3-bit)
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_ADDR = S_ADDR,
    ST_DHI  = S_DHI,
    ST_DLO  = S_DLO,
    ST_CSUM = S_CSUM
  } state_e;

  // Frame layout: HEADER, ADDR, DHI, DLO, CSUM
  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam int         FRAME_LEN      = 5;

  // Receiver baud generation
  localparam int CLK_FREQ_HZ  = 50_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and flags the cycle
// in which the count sits at its terminal value LIMIT-1. A clear in that same
// cycle suppresses the flag, so activity always beats the timeout.
module uart_idle_timer #(
  parameter int          W     = 24,
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] TERM = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign expired = en && !clr && (cnt == TERM);

  // Counter: cleared on activity or expiry, otherwise advances while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte command frames (HEADER, ADDR, DHI, DLO, CSUM) from the
// UART byte receiver, checks the 8-bit checksum and issues one register-write
// strobe per valid frame. An inter-byte timeout drops truncated frames.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 24'd1_000_000,
  parameter int          TO_W           = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  data_byte,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  // Checksum: 8-bit sum of the payload, carries discarded
  function automatic logic [7:0] csum8(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
    return a + b + c;
  endfunction

  state_e     state, state_nxt;
  logic       wr_nxt, ferr_nxt, terr_nxt;
  logic [7:0] addr_q, dhi_q, dlo_q;
  logic       to_clr, to_en, to_expired;

  // The counter only runs inside a frame; every accepted byte restarts it
  assign to_clr = rx_done || (state == ST_IDLE);
  assign to_en  = (state != ST_IDLE);

  uart_idle_timer #(
    .W     (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // Next-state and pulse decode; a byte in the terminal cycle wins over timeout
  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    ferr_nxt  = 1'b0;
    terr_nxt  = 1'b0;
    if (rx_done) begin
      case (state)
        ST_IDLE: if (data_byte == HEADER) state_nxt = ST_ADDR;
        ST_ADDR: state_nxt = ST_DHI;
        ST_DHI:  state_nxt = ST_DLO;
        ST_DLO:  state_nxt = ST_CSUM;
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          if (data_byte == csum8(addr_q, dhi_q, dlo_q)) wr_nxt = 1'b1;
          else                                          ferr_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (to_expired) begin
      state_nxt = ST_IDLE;
      terr_nxt  = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      reg_wr      <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 16'h0000;
    end else begin
      state       <= state_nxt;
      reg_wr      <= wr_nxt;
      frame_err   <= ferr_nxt;
      timeout_err <= terr_nxt;
      busy        <= (state_nxt != ST_IDLE);
      if (wr_nxt) begin
        reg_addr  <= addr_q;
        reg_wdata <= {dhi_q, dlo_q};
      end
    end
  end

  // Payload latches; a timed-out partial frame is wiped
  always_ff @(posedge clk) begin
    if (rx_done) begin
      case (state)
        ST_ADDR: addr_q <= data_byte;
        ST_DHI:  dhi_q  <= data_byte;
        ST_DLO:  dlo_q  <= data_byte;
        default: ;
      endcase
    end else if (to_expired) begin
      addr_q <= 8'h00;
      dhi_q  <= 8'h00;
      dlo_q  <= 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a short (16-cycle) timeout.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  data_byte;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0, ferr_cnt = 0, terr_cnt = 0, excl_viol = 0;
  int wr0, ferr0, terr0;

  uart_frame_parser #(
    .HEADER         (8'hAA),
    .TIMEOUT_CYCLES (16),
    .TO_W           (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_done     (rx_done),
    .data_byte   (data_byte),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters and exclusivity watch (sees the previous cycle's outputs)
  always @(posedge clk) begin
    if (reg_wr)      wr_cnt++;
    if (frame_err)   ferr_cnt++;
    if (timeout_err) terr_cnt++;
    if ((int'(reg_wr) + int'(frame_err) + int'(timeout_err)) > 1) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a byte for one cycle starting at the next falling edge
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_done   = 1'b1;
    data_byte = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  task automatic put_gap(input logic [7:0] b, input int gap);
    put(b);
    if (gap > 1) idle(gap - 1);
  endtask

  // Full frame with strobes 'gap' cycles apart; returns one cycle after CSUM
  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c,
                            input int gap);
    put_gap(8'hAA, gap);
    put_gap(a, gap);
    put_gap(h, gap);
    put_gap(l, gap);
    put(c);
    idle(1);
  endtask

  task automatic snap();
    wr0 = wr_cnt; ferr0 = ferr_cnt; terr0 = terr_cnt;
  endtask

  task automatic check_counts(input string tag, input int ewr, input int eferr, input int eterr);
    idle(2);
    check({tag, "_nwr"},   wr_cnt - wr0,     ewr);
    check({tag, "_nferr"}, ferr_cnt - ferr0, eferr);
    check({tag, "_nterr"}, terr_cnt - terr0, eterr);
  endtask

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; data_byte = 8'h00;
    idle(2);
    check("rst_wr",    reg_wr,      1'b0);
    check("rst_addr",  reg_addr,    8'h00);
    check("rst_wdata", reg_wdata,   16'h0000);
    check("rst_ferr",  frame_err,   1'b0);
    check("rst_terr",  timeout_err, 1'b0);
    check("rst_busy",  busy,        1'b0);
    rst_n = 1'b1;
    idle(2);

    // Valid frame, bytes 10 cycles apart
    snap();
    send_frame(8'h12, 8'h34, 8'h56, 8'h9C, 10);
    check("t1_wr",    reg_wr,    1'b1);
    check("t1_addr",  reg_addr,  8'h12);
    check("t1_wdata", reg_wdata, 16'h3456);
    check("t1_ferr",  frame_err, 1'b0);
    check("t1_busy",  busy,      1'b0);
    idle(1);
    check("t1_wr_off", reg_wr, 1'b0);
    check_counts("t1", 1, 0, 0);

    // Bad checksum keeps outputs, then a good frame
    snap();
    send_frame(8'h12, 8'h34, 8'h56, 8'h00, 3);
    check("t2_ferr",  frame_err, 1'b1);
    check("t2_wr",    reg_wr,    1'b0);
    check("t2_addr",  reg_addr,  8'h12);
    check("t2_wdata", reg_wdata, 16'h3456);
    idle(1);
    check("t2_ferr_off", frame_err, 1'b0);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03, 3);
    check("t2b_wr",    reg_wr,    1'b1);
    check("t2b_addr",  reg_addr,  8'h01);
    check("t2b_wdata", reg_wdata, 16'h0002);
    check_counts("t2", 1, 1, 0);

    // Junk in idle is dropped; checksum wrap-around
    snap();
    put(8'h00); put(8'hFF); put(8'h55); idle(1);
    check("t3_junk_busy", busy, 1'b0);
    send_frame(8'hFF, 8'hFF, 8'h03, 8'h03, 2);
    check("t3_ferr", frame_err, 1'b1);
    check("t3_wr",   reg_wr,    1'b0);
    check("t3_addr", reg_addr,  8'h01);
    send_frame(8'hFF, 8'hFF, 8'h03, 8'h01, 2);
    check("t3b_wr",    reg_wr,    1'b1);
    check("t3b_addr",  reg_addr,  8'hFF);
    check("t3b_wdata", reg_wdata, 16'hFF03);
    check_counts("t3", 1, 1, 0);

    // Timeout 16 cycles after the last strobe
    snap();
    put(8'hAA); put(8'h12); idle(1);
    check("t4_busy_rise", busy, 1'b1);
    idle(15);
    check("t4_terr_early", timeout_err, 1'b0);
    check("t4_busy_hold",  busy,        1'b1);
    idle(1);
    check("t4_terr",      timeout_err, 1'b1);
    check("t4_busy_fall", busy,        1'b0);
    idle(1);
    check("t4_terr_off", timeout_err, 1'b0);
    check_counts("t4", 0, 0, 1);

    // Byte on the terminal-count cycle beats the timeout
    snap();
    put(8'hAA); put(8'h12); idle(15); put(8'h34); idle(1);
    check("t4b_terr", timeout_err, 1'b0);
    check("t4b_busy", busy,        1'b1);
    put(8'h56); put(8'h9C); idle(1);
    check("t4b_wr",    reg_wr,    1'b1);
    check("t4b_addr",  reg_addr,  8'h12);
    check("t4b_wdata", reg_wdata, 16'h3456);
    check_counts("t4b", 1, 0, 0);

    // Back-to-back strobes; next header arrives while reg_wr is high
    snap();
    put(8'hAA); put(8'h80); put(8'h00); put(8'h01); put(8'h81);
    put(8'hAA);
    check("t5_wr",    reg_wr,    1'b1);
    check("t5_addr",  reg_addr,  8'h80);
    check("t5_wdata", reg_wdata, 16'h0001);
    put(8'h01); put(8'h00); put(8'h02); put(8'h03); idle(1);
    check("t5b_wr",    reg_wr,    1'b1);
    check("t5b_addr",  reg_addr,  8'h01);
    check("t5b_wdata", reg_wdata, 16'h0002);
    check_counts("t5", 2, 0, 0);

    // Asynchronous reset mid-frame
    snap();
    put(8'hAA); put(8'h12); put(8'h34); idle(1);
    check("t6_busy_pre", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_busy",  busy,        1'b0);
    check("t6_addr",  reg_addr,    8'h00);
    check("t6_wdata", reg_wdata,   16'h0000);
    check("t6_wr",    reg_wr,      1'b0);
    check("t6_ferr",  frame_err,   1'b0);
    check("t6_terr",  timeout_err, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h12, 8'h34, 8'h56, 8'h9C, 1);
    check("t6b_wr",    reg_wr,    1'b1);
    check("t6b_addr",  reg_addr,  8'h12);
    check("t6b_wdata", reg_wdata, 16'h3456);
    check_counts("t6", 1, 0, 0);

    check("pulse_exclusive", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
